alu_ctl_pipe: RTL and testbench



---
 rtl/alu_ctl_pkg.sv | 73 +++++++
 rtl/alu_ctl_decode.sv | 115 +++++++++++
 rtl/alu_ctl_pipe.sv | 136 +++++++++++++
 tb/tb_alu_ctl_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_pkg.sv
// alu_ctl_pkg: shared constants for the ALU control stage.
//   - 7-bit ALU op / branch-condition codes (base and M extension)
//   - RV32 major opcodes and the funct7 values the decoder distinguishes
//   - FSM state enum for the output register of alu_ctl_pipe
//   - base_op(): funct3 -> ALU op for the register/immediate ALU forms
package alu_ctl_pkg;

  // Base ALU ops
  localparam logic [6:0] OP_AND   = 7'b0000000;
  localparam logic [6:0] OP_OR    = 7'b0000001;
  localparam logic [6:0] OP_ADD   = 7'b0000010;
  localparam logic [6:0] OP_SRL   = 7'b0000011;
  localparam logic [6:0] OP_SRA   = 7'b0000100;
  localparam logic [6:0] OP_SLL   = 7'b0000101;
  localparam logic [6:0] OP_SUB   = 7'b0000110;
  localparam logic [6:0] OP_SLT   = 7'b0000111;
  localparam logic [6:0] OP_XOR   = 7'b0001000;
  localparam logic [6:0] OP_CSRRW = 7'b0001001;
  localparam logic [6:0] OP_CSRRS = 7'b0001010;
  localparam logic [6:0] OP_CSRRC = 7'b0001011;
  localparam logic [6:0] OP_NOP   = 7'b0001111;

  // Branches: condition in [6:4], SUB low nibble in [3:0]
  localparam logic [6:0] OP_BEQ   = 7'b0010110;
  localparam logic [6:0] OP_BNE   = 7'b0100110;
  localparam logic [6:0] OP_BLT   = 7'b0110110;
  localparam logic [6:0] OP_BGE   = 7'b1000110;
  localparam logic [6:0] OP_BLTU  = 7'b1010110;
  localparam logic [6:0] OP_BGEU  = 7'b1100110;

  // M extension: condition 111, bit 3 clear, funct3 in [2:0]
  localparam logic [2:0] COND_M   = 3'b111;

  // RV32 major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // The op set has no unsigned-compare code, so SLTU/SLTIU share SLT.
  function automatic logic [6:0] base_op(input logic [2:0] f3);
    logic [6:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLT;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: purely combinational RV32 opcode/funct3/funct7 to ALU
// control decode.
//   opcode_i, funct3_i, funct7_i : instruction fields
//   ctl_o      : 7-bit ALU control word (NOP when illegal)
//   illegal_o  : encoding is not a legal instruction for this core
//   multi_o    : op is an M-extension multi-cycle op
//   lat_div_o  : latency select for multi-cycle ops (1 = DIV/REM, 0 = MUL)
module alu_ctl_decode
  import alu_ctl_pkg::*;
#(
  parameter int unsigned ENABLE_M = 1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [6:0] ctl_o,
  output logic       illegal_o,
  output logic       multi_o,
  output logic       lat_div_o
);

  always_comb begin
    ctl_o     = OP_NOP;
    illegal_o = 1'b0;
    multi_o   = 1'b0;
    lat_div_o = 1'b0;

    case (opcode_i)
      OPC_LUI, OPC_AUIPC: ctl_o = OP_ADD;

      OPC_JAL, OPC_JALR: ctl_o = OP_NOP;

      OPC_LOAD: begin
        case (funct3_i)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ctl_o = OP_ADD;
          default: illegal_o = 1'b1;
        endcase
      end

      OPC_STORE: begin
        case (funct3_i)
          3'b000, 3'b001, 3'b010: ctl_o = OP_ADD;
          default: illegal_o = 1'b1;
        endcase
      end

      OPC_BRANCH: begin
        case (funct3_i)
          3'b000:  ctl_o = OP_BEQ;
          3'b001:  ctl_o = OP_BNE;
          3'b100:  ctl_o = OP_BLT;
          3'b101:  ctl_o = OP_BGE;
          3'b110:  ctl_o = OP_BLTU;
          3'b111:  ctl_o = OP_BGEU;
          default: illegal_o = 1'b1;
        endcase
      end

      OPC_OP_IMM: begin
        case (funct3_i)
          3'b001: begin
            if (funct7_i == F7_BASE) ctl_o = OP_SLL;
            else                     illegal_o = 1'b1;
          end
          3'b101: begin
            if (funct7_i == F7_BASE)     ctl_o = OP_SRL;
            else if (funct7_i == F7_ALT) ctl_o = OP_SRA;
            else                         illegal_o = 1'b1;
          end
          default: ctl_o = base_op(funct3_i);
        endcase
      end

      OPC_OP: begin
        case (funct7_i)
          F7_BASE: ctl_o = base_op(funct3_i);
          F7_ALT: begin
            if (funct3_i == 3'b000)      ctl_o = OP_SUB;
            else if (funct3_i == 3'b101) ctl_o = OP_SRA;
            else                         illegal_o = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M != 0) begin
              ctl_o     = {COND_M, 1'b0, funct3_i};
              multi_o   = 1'b1;
              lat_div_o = funct3_i[2];
            end else begin
              illegal_o = 1'b1;
            end
          end
          default: illegal_o = 1'b1;
        endcase
      end

      OPC_SYSTEM: begin
        if (funct3_i == 3'b000) begin
          ctl_o = OP_NOP;
        end else if (funct3_i == 3'b100) begin
          illegal_o = 1'b1;
        end else begin
          case (funct3_i[1:0])
            2'b01:   ctl_o = OP_CSRRW;
            2'b10:   ctl_o = OP_CSRRS;
            default: ctl_o = OP_CSRRC;
          endcase
        end
      end

      default: illegal_o = 1'b1;
    endcase

    if (illegal_o) ctl_o = OP_NOP;
  end

endmodule

// File: rtl/alu_ctl_pipe.sv
// alu_ctl_pipe: registered, handshaked ALU control stage between decode and
// the ALU. Decodes the instruction into a control word, holds it in a
// one-entry output register and times multi-cycle M ops with a counter.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop held / in-flight op
//   in_valid/in_ready : input handshake from decode
//   opcode/funct3/funct7 : instruction fields
//   out_valid/out_ready  : output handshake to the ALU
//   alu_ctl           : registered control word (bits above [6] are 0)
//   busy              : multi-cycle op counting down
//   illegal           : held op was an illegal encoding
module alu_ctl_pipe
  import alu_ctl_pkg::*;
#(
  parameter int unsigned CTL_W      = 7,
  parameter int unsigned ENABLE_M   = 1,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             busy,
  output logic             illegal
);

  localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  // Counter preload is L-1; zero means the op completes in one cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       ctl_q, ctl_d;
  logic             ill_q, ill_d;

  logic [6:0]       dec_ctl;
  logic             dec_ill;
  logic             dec_multi;
  logic             dec_lat_div;
  logic [CNT_W-1:0] lat_load;
  logic             accept;

  alu_ctl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .ctl_o     (dec_ctl),
    .illegal_o (dec_ill),
    .multi_o   (dec_multi),
    .lat_div_o (dec_lat_div)
  );

  assign lat_load = dec_lat_div ? DIV_LOAD : MUL_LOAD;
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      ctl_q   <= OP_NOP;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      ill_q   <= ill_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    ill_d   = ill_q;

    if (flush) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
      ctl_d   = OP_NOP;
      ill_d   = 1'b0;
    end else if (accept) begin
      ctl_d = dec_ctl;
      ill_d = dec_ill;
      if (dec_multi && (lat_load != '0)) begin
        state_d = ST_WAIT;
        cnt_d   = lat_load;
      end else begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          // <= 1 rather than == 1 so the counter can never wrap.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = !rst && !flush &&
                ((state_q == ST_EMPTY) || ((state_q == ST_HOLD) && out_ready));
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q == ST_WAIT);
    illegal   = ill_q;
    alu_ctl   = '0;
    alu_ctl[6:0] = ctl_q;
  end

endmodule

// File: tb/tb_alu_ctl_pipe.sv
module tb_alu_ctl_pipe;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic       in_ready, out_valid, busy, illegal;
  logic [6:0] alu_ctl;
  logic       nom_in_ready, nom_out_valid, nom_busy, nom_illegal;
  logic [6:0] nom_alu_ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_ctl_pipe #(
    .CTL_W      (7),
    .ENABLE_M   (1),
    .MUL_CYCLES (2),
    .DIV_CYCLES (33)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctl   (alu_ctl),
    .busy      (busy),
    .illegal   (illegal)
  );

  alu_ctl_pipe #(
    .CTL_W      (7),
    .ENABLE_M   (0),
    .MUL_CYCLES (2),
    .DIV_CYCLES (33)
  ) dut_nom (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (nom_in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (nom_out_valid),
    .out_ready (out_ready),
    .alu_ctl   (nom_alu_ctl),
    .busy      (nom_busy),
    .illegal   (nom_illegal)
  );

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [6:0] ctl;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    in_valid = v;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  // Called right after the accept edge (cycle 1); runs until out_valid with a budget.
  task automatic measure(input logic [6:0] exp_ctl, output int cyc, output int nbusy,
                         output int nbadctl, output int nready);
    cyc = 1; nbusy = 0; nbadctl = 0; nready = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) nbusy++;
      if (alu_ctl !== exp_ctl) nbadctl++;
      if (in_ready) nready++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, nbusy, nbadctl, nready;

    // op, f3, f7, expected ctl, expected illegal
    vecs.push_back('{7'b0110111, 3'b000, 7'b0000000, 7'b0000010, 1'b0}); // LUI
    vecs.push_back('{7'b1101111, 3'b000, 7'b0000000, 7'b0001111, 1'b0}); // JAL
    vecs.push_back('{7'b0000011, 3'b011, 7'b0000000, 7'b0001111, 1'b1}); // load f3=011
    vecs.push_back('{7'b0000011, 3'b100, 7'b0000000, 7'b0000010, 1'b0}); // LBU
    vecs.push_back('{7'b0100011, 3'b010, 7'b0000000, 7'b0000010, 1'b0}); // SW
    vecs.push_back('{7'b0100011, 3'b100, 7'b0000000, 7'b0001111, 1'b1}); // store f3=100
    vecs.push_back('{7'b1100011, 3'b000, 7'b0000000, 7'b0010110, 1'b0}); // BEQ
    vecs.push_back('{7'b1100011, 3'b100, 7'b0000000, 7'b0110110, 1'b0}); // BLT
    vecs.push_back('{7'b1100011, 3'b010, 7'b0000000, 7'b0001111, 1'b1}); // branch f3=010
    vecs.push_back('{7'b0010011, 3'b001, 7'b0100000, 7'b0001111, 1'b1}); // SLLI bad f7
    vecs.push_back('{7'b0010011, 3'b101, 7'b0100000, 7'b0000100, 1'b0}); // SRAI
    vecs.push_back('{7'b0010011, 3'b100, 7'b0000000, 7'b0001000, 1'b0}); // XORI
    vecs.push_back('{7'b0010011, 3'b111, 7'b0000000, 7'b0000000, 1'b0}); // ANDI
    vecs.push_back('{7'b0110011, 3'b001, 7'b0100000, 7'b0001111, 1'b1}); // OP alt f3=001
    vecs.push_back('{7'b0110011, 3'b101, 7'b0000000, 7'b0000011, 1'b0}); // SRL
    vecs.push_back('{7'b0110011, 3'b110, 7'b0000000, 7'b0000001, 1'b0}); // OR
    vecs.push_back('{7'b1110011, 3'b001, 7'b0000000, 7'b0001001, 1'b0}); // CSRRW
    vecs.push_back('{7'b1110011, 3'b011, 7'b0000000, 7'b0001011, 1'b0}); // CSRRC
    vecs.push_back('{7'b1110011, 3'b000, 7'b0000000, 7'b0001111, 1'b0}); // ECALL
    vecs.push_back('{7'b1110011, 3'b100, 7'b0000000, 7'b0001111, 1'b1}); // SYSTEM f3=100
    vecs.push_back('{7'b1111111, 3'b000, 7'b0000000, 7'b0001111, 1'b1}); // unknown opcode

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 7'b0, 3'b0, 7'b0);
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ctl", alu_ctl, 7'b0001111);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    // ADD with out_ready high
    out_ready = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_ctl", alu_ctl, 7'b0000010);
    chk("add_in_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("add_drain", out_valid, 0);

    // BGEU held while out_ready low, then SUB
    out_ready = 1'b0;
    drive(1'b1, 7'b1100011, 3'b111, 7'b0000000);
    tick();
    chk("bgeu_valid", out_valid, 1);
    chk("bgeu_ctl", alu_ctl, 7'b1100110);
    drive(1'b1, 7'b0110011, 3'b000, 7'b0100000);
    for (int i = 0; i < 2; i++) begin
      chk("bgeu_hold_in_ready", in_ready, 0);
      tick();
      chk("bgeu_hold_valid", out_valid, 1);
      chk("bgeu_hold_ctl", alu_ctl, 7'b1100110);
    end
    out_ready = 1'b1; #1;
    chk("sub_in_ready", in_ready, 1);
    tick();
    chk("sub_valid", out_valid, 1);
    chk("sub_ctl", alu_ctl, 7'b0000110);
    in_valid = 1'b0;
    tick();
    chk("sub_drain", out_valid, 0);

    // DIV, 33-cycle latency, consumer stalls one extra cycle
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
    tick();
    in_valid = 1'b0;
    measure(7'b1110100, cyc, nbusy, nbadctl, nready);
    chk("div_latency", cyc, 33);
    chk("div_busy_cycles", nbusy, 32);
    chk("div_ctl_unstable", nbadctl, 0);
    chk("div_in_ready_cycles", nready, 0);
    chk("div_ctl", alu_ctl, 7'b1110100);
    chk("div_busy_at_valid", busy, 0);
    tick();
    chk("div_held_valid", out_valid, 1);
    chk("div_held_in_ready", in_ready, 0);
    out_ready = 1'b1; #1;
    chk("div_hs_in_ready", in_ready, 1);
    tick();
    chk("div_drain", out_valid, 0);

    // MUL, 2-cycle latency
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
    tick();
    in_valid = 1'b0;
    measure(7'b1110000, cyc, nbusy, nbadctl, nready);
    chk("mul_latency", cyc, 2);
    chk("mul_busy_cycles", nbusy, 1);
    chk("mul_ctl", alu_ctl, 7'b1110000);
    tick();

    // MUL with ENABLE_M = 0: illegal, single cycle
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
    tick();
    in_valid = 1'b0;
    chk("nom_mul_illegal", nom_illegal, 1);
    chk("nom_mul_ctl", nom_alu_ctl, 7'b0001111);
    chk("nom_mul_valid", nom_out_valid, 1);
    chk("nom_mul_busy", nom_busy, 0);
    tick(); tick(); tick();
    chk("mul_drained", out_valid, 0);

    // Back-to-back directed vectors
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_ctl", i), alu_ctl, vecs[i].ctl);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
    end
    in_valid = 1'b0;
    tick();

    // Flush at cycle 10 of DIV with a competing ADD
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctl", alu_ctl, 7'b0001111);
    chk("flush_illegal", illegal, 0);
    #1;
    chk("post_flush_in_ready", in_ready, 1);
    tick();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_ctl", alu_ctl, 7'b0000010);
    in_valid = 1'b0;
    tick();

    // Flush clears a held illegal op
    out_ready = 1'b0;
    drive(1'b1, 7'b1111111, 3'b000, 7'b0000000);
    tick();
    in_valid = 1'b0;
    chk("ill_held", illegal, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ill_flush_illegal", illegal, 0);
    chk("ill_flush_valid", out_valid, 0);

    // Reset during WAIT
    drive(1'b1, 7'b0110011, 3'b101, 7'b0000001);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rstw_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("rstw_busy", busy, 0);
    chk("rstw_valid", out_valid, 0);
    chk("rstw_ctl", alu_ctl, 7'b0001111);
    chk("rstw_illegal", illegal, 0);
    chk("rstw_in_ready", in_ready, 0);
    rst = 1'b0; #1;
    chk("rstw_post_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
